// File: rtl/alu_pkg.sv
// Shared widths, opcode encoding and response-register state for the ALU and its arbiter.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational integer ALU; unassigned opcodes produce zero.
module alu #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic [DATA_W-1:0] i_operand_a,
    input  logic [DATA_W-1:0] i_operand_b,
    input  logic [OP_W-1:0]   i_alu_op,
    output logic [DATA_W-1:0] o_alu_data
);
    import alu_pkg::*;

    localparam int SHAMT_W = $clog2(DATA_W);

    logic [SHAMT_W-1:0] w_shamt;

    assign w_shamt = i_operand_b[SHAMT_W-1:0];

    always_comb begin
        o_alu_data = '0;
        case (i_alu_op)
            ALU_ADD:  o_alu_data = i_operand_a + i_operand_b;
            ALU_SUB:  o_alu_data = i_operand_a - i_operand_b;
            ALU_SLL:  o_alu_data = i_operand_a << w_shamt;
            ALU_SLT:  o_alu_data = {{(DATA_W-1){1'b0}}, $signed(i_operand_a) < $signed(i_operand_b)};
            ALU_SLTU: o_alu_data = {{(DATA_W-1){1'b0}}, i_operand_a < i_operand_b};
            ALU_XOR:  o_alu_data = i_operand_a ^ i_operand_b;
            ALU_SRL:  o_alu_data = i_operand_a >> w_shamt;
            ALU_SRA:  o_alu_data = $unsigned($signed(i_operand_a) >>> w_shamt);
            ALU_OR:   o_alu_data = i_operand_a | i_operand_b;
            ALU_AND:  o_alu_data = i_operand_a & i_operand_b;
            default:  o_alu_data = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the core datapath (port 0) and the debug injector (port 1).
// Handshake: a request transfers on a cycle where valid & ready; ready only goes to the granted port.
module alu_arbiter #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [DATA_W-1:0] i_req0_operand_a,
    input  logic [DATA_W-1:0] i_req0_operand_b,
    input  logic [OP_W-1:0]   i_req0_alu_op,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [DATA_W-1:0] i_req1_operand_a,
    input  logic [DATA_W-1:0] i_req1_operand_b,
    input  logic [OP_W-1:0]   i_req1_alu_op,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_id
);
    import alu_pkg::*;

    rsp_state_e        r_state;
    rsp_state_e        w_state_next;
    logic              r_last_grant;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_id;

    logic              w_can_accept;
    logic              w_grant_any;
    logic              w_grant_id;
    logic              w_accept;
    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_b;
    logic [OP_W-1:0]   w_alu_op;
    logic [DATA_W-1:0] w_alu_data;

    assign w_can_accept = (r_state == RSP_EMPTY) | i_rsp_ready;
    assign w_grant_any  = i_req0_valid | i_req1_valid;
    // With a single requester its own index wins; on conflict the port not served last wins.
    assign w_grant_id   = (i_req0_valid & i_req1_valid) ? ~r_last_grant : i_req1_valid;
    assign w_accept     = w_grant_any & w_can_accept;

    assign o_req0_ready = w_grant_any & ~w_grant_id & w_can_accept;
    assign o_req1_ready = w_grant_any &  w_grant_id & w_can_accept;

    assign w_alu_a  = w_grant_id ? i_req1_operand_a : i_req0_operand_a;
    assign w_alu_b  = w_grant_id ? i_req1_operand_b : i_req0_operand_b;
    assign w_alu_op = w_grant_id ? i_req1_alu_op    : i_req0_alu_op;

    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .i_operand_a (w_alu_a),
        .i_operand_b (w_alu_b),
        .i_alu_op    (w_alu_op),
        .o_alu_data  (w_alu_data)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RSP_EMPTY: if (w_accept) w_state_next = RSP_FULL;
            RSP_FULL:  if (i_rsp_ready) w_state_next = w_accept ? RSP_FULL : RSP_EMPTY;
            default:   w_state_next = RSP_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= RSP_EMPTY;
            r_last_grant <= 1'b1;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_rsp_data   <= w_alu_data;
                r_rsp_id     <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
        end
    end

    assign o_rsp_valid = (r_state == RSP_FULL);
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_req0_valid, i_req1_valid;
    logic          o_req0_ready, o_req1_ready;
    logic [DW-1:0] i_req0_operand_a, i_req0_operand_b;
    logic [DW-1:0] i_req1_operand_a, i_req1_operand_b;
    logic [OW-1:0] i_req0_alu_op, i_req1_alu_op;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_id;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: response slot contents and the requester served most recently.
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_id;
    logic          m_last;

    always #5 i_clk = ~i_clk;

    alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_req0_valid     (i_req0_valid),
        .o_req0_ready     (o_req0_ready),
        .i_req0_operand_a (i_req0_operand_a),
        .i_req0_operand_b (i_req0_operand_b),
        .i_req0_alu_op    (i_req0_alu_op),
        .i_req1_valid     (i_req1_valid),
        .o_req1_ready     (o_req1_ready),
        .i_req1_operand_a (i_req1_operand_a),
        .i_req1_operand_b (i_req1_operand_b),
        .i_req1_alu_op    (i_req1_alu_op),
        .o_rsp_valid      (o_rsp_valid),
        .i_rsp_ready      (i_rsp_ready),
        .o_rsp_data       (o_rsp_data),
        .o_rsp_id         (o_rsp_id)
    );

    function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [OW-1:0] op);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return $unsigned($signed(a) >>> sh);
            4'd8:    return a | b;
            4'd9:    return a & b;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp();
        chk("rsp_valid", {31'd0, o_rsp_valid}, {31'd0, m_valid});
        chk("rsp_data", o_rsp_data, m_data);
        chk("rsp_id", {31'd0, o_rsp_id}, {31'd0, m_id});
    endtask

    task automatic do_reset();
        i_rst        = 1'b1;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 1'b0;
        m_last  = 1'b1;
        check_rsp();
    endtask

    // One clock of traffic: drive, check the ready decision, clock, check the response slot.
    task automatic cycle(input logic v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input logic [OW-1:0] op0, input logic v1, input logic [DW-1:0] a1,
                         input logic [DW-1:0] b1, input logic [OW-1:0] op1, input logic rr,
                         output logic acc0, output logic acc1);
        int  winner;
        logic room;
        i_req0_valid = v0; i_req0_operand_a = a0; i_req0_operand_b = b0; i_req0_alu_op = op0;
        i_req1_valid = v1; i_req1_operand_a = a1; i_req1_operand_b = b1; i_req1_alu_op = op1;
        i_rsp_ready  = rr;
        #1;
        if (v0 && v1)  winner = (m_last == 1'b0) ? 1 : 0;
        else if (v0)   winner = 0;
        else if (v1)   winner = 1;
        else           winner = -1;
        room = !m_valid || rr;
        acc0 = (winner == 0) && room;
        acc1 = (winner == 1) && room;
        chk("req0_ready", {31'd0, o_req0_ready}, {31'd0, acc0});
        chk("req1_ready", {31'd0, o_req1_ready}, {31'd0, acc1});
        @(posedge i_clk);
        #1;
        if (acc0 || acc1) begin
            m_valid = 1'b1;
            m_data  = acc0 ? ref_alu(a0, b0, op0) : ref_alu(a1, b1, op1);
            m_id    = acc1;
            m_last  = acc1;
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end
        check_rsp();
    endtask

    initial begin
        logic          g0, g1;
        logic          p0, p1;
        logic [DW-1:0] ra0, rb0, ra1, rb1;
        logic [OW-1:0] rop0, rop1;

        i_rst = 1'b1; i_rsp_ready = 1'b1;
        i_req0_valid = 1'b0; i_req0_operand_a = '0; i_req0_operand_b = '0; i_req0_alu_op = '0;
        i_req1_valid = 1'b0; i_req1_operand_a = '0; i_req1_operand_b = '0; i_req1_alu_op = '0;
        do_reset();

        // Single request, then backpressure for 5 cycles with both ports waiting.
        cycle(1, 32'h34, 32'h23, 4'd0, 0, 0, 0, 4'd0, 1, g0, g1);
        chk("first_result", o_rsp_data, 32'h57);
        for (int i = 0; i < 5; i++)
            cycle(1, 32'h5, 32'h6, 4'd0, 1, 32'h9, 32'h4, 4'd1, 0, g0, g1);
        chk("held_result", o_rsp_data, 32'h57);
        cycle(1, 32'h5, 32'h6, 4'd0, 1, 32'h9, 32'h4, 4'd1, 1, g0, g1);
        cycle(1, 32'h5, 32'h6, 4'd0, 0, 0, 0, 4'd0, 1, g0, g1);
        cycle(0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 1, g0, g1);

        // Back-to-back conflicts from reset alternate 0,1,0,1 with no bubbles.
        do_reset();
        for (int i = 0; i < 6; i++)
            cycle(1, 32'd1, 32'd2, 4'd0, 1, 32'd10, 32'd3, 4'd1, 1, g0, g1);
        cycle(0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 1, g0, g1);

        // Wrap-around on requester 1.
        cycle(0, 0, 0, 4'd0, 1, 32'hFFFF_FFFF, 32'h1, 4'd0, 1, g0, g1);
        chk("wrap_data", o_rsp_data, 32'h0);

        // Reset while a response is held.
        cycle(1, 32'h100, 32'h1, 4'd1, 0, 0, 0, 4'd0, 0, g0, g1);
        cycle(0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, g0, g1);
        do_reset();
        cycle(1, 32'h7, 32'h3, 4'd5, 1, 32'h8, 32'h2, 4'd2, 1, g0, g1);
        chk("post_reset_grant0", {31'd0, g0}, 32'd1);

        // Drain, idle for 10 cycles, then a conflict shows the pointer did not move.
        for (int i = 0; i < 12; i++)
            cycle(0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 1, g0, g1);
        cycle(1, 32'h3, 32'h7, 4'd3, 1, 32'h3, 32'h7, 4'd4, 1, g0, g1);

        // Randomized traffic: requesters hold their request until accepted.
        p0 = 1'b0; p1 = 1'b0;
        ra0 = '0; rb0 = '0; ra1 = '0; rb1 = '0; rop0 = '0; rop1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1'b1; ra0 = $urandom; rb0 = $urandom; rop0 = OW'($urandom_range(0, 11));
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1; ra1 = $urandom; rb1 = $urandom; rop1 = OW'($urandom_range(0, 11));
            end
            cycle(p0, ra0, rb0, rop0, p1, ra1, rb1, rop1, $urandom_range(0, 3) != 0, g0, g1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                p0 = 1'b0; p1 = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance between two requesters. Port 0 is the core datapath; port 1 is the debug/test injector.
- Arbitration is round-robin, with a valid/ready handshake on each request port.
- Each accepted operation is computed combinationally by the shared ALU. The result is captured in a single-entry response register that carries the requester ID.
- Sits between the issue logic and the ALU in the multi-cycle/debug variant of the core.

Parameters:
- DATA_W, 32, operand and result width.
- OP_W, 4, ALU opcode width. Must match `i_alu_op` of `alu`.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req0_valid  in  1  requester 0 presents an operation.
- o_req0_ready  out  1  requester 0 operation accepted this cycle (when i_req0_valid=1).
- i_req0_operand_a  in  DATA_W  requester 0 operand A.
- i_req0_operand_b  in  DATA_W  requester 0 operand B.
- i_req0_alu_op  in  OP_W  requester 0 opcode.
- i_req1_valid / o_req1_ready / i_req1_operand_a / i_req1_operand_b / i_req1_alu_op: same meaning and widths for requester 1.
- o_rsp_valid  out  1  response register holds a result.
- i_rsp_ready  in  1  consumer takes the response this cycle.
- o_rsp_data  out  DATA_W  registered ALU result.
- o_rsp_id  out  1  requester that issued the result (0 or 1).

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first conflict.
  - Reset mid-operation discards any held response. No partial accept survives.
- Response register is a two-state FSM:
  - EMPTY (o_rsp_valid=0) and FULL (o_rsp_valid=1).
  - can_accept = EMPTY | (FULL & i_rsp_ready).
- Grant, combinational:
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant the one != last_grant.
  - Neither valid: no grant.
- Ready outputs: o_reqK_ready = grantK & can_accept.
  - Ready may depend on the other port's valid.
  - Ready is never asserted to a non-granted port.
- ALU inputs are muxed from the granted port. With no grant, requester 0's fields are driven; the result is unused.
- Accept = i_reqK_valid & o_reqK_ready. On accept, at the next edge:
  - o_rsp_data <= ALU result.
  - o_rsp_id <= K.
  - o_rsp_valid <= 1.
  - last_grant <= K.
- Timing: latency is 1 cycle from accept to o_rsp_valid. Throughput is 1 op/cycle while i_rsp_ready=1.
- FULL & i_rsp_ready & no accept: o_rsp_valid <= 0. Data and ID hold their last values.
- FULL & !i_rsp_ready:
  - Both ready outputs are 0.
  - Response data and ID are stable until taken.
  - last_grant does not change.
- Simultaneous pop and push in the same cycle: the new result replaces the old one. No bubble.
- Arithmetic: width, wrap-around and opcode semantics are entirely those of `alu`. The arbiter does no arithmetic.
- A requester must hold valid and its fields stable until it sees ready. The arbiter does not register requests.

Decomposition:
- Package `alu_pkg`:
  - DATA_W and OP_W constants.
  - Opcode enum `alu_op_e` (ALU_ADD=4'b0000, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND).
  - Response FSM state typedef {RSP_EMPTY, RSP_FULL}.
- Sub-module: the existing `alu`, instantiated once (i_operand_a, i_operand_b, i_alu_op, o_alu_data).
- The round-robin grant logic stays inline.

Test Plan:
- Reset, then req0 only: a=0x34, b=0x23, op=ADD, i_rsp_ready=1 → o_req0_ready=1 in the same cycle. Next cycle o_rsp_valid=1, data=0x57, id=0.
- Both valid every cycle, i_rsp_ready=1:
  - req0 ADD 1+2, req1 SUB 10-3.
  - Grants alternate 0,1,0,1 (first grant 0).
  - Responses alternate (0x3,id0), (0x7,id1).
  - No idle cycles.
- Backpressure: i_rsp_ready=0 after the first response (0x57) → both ready outputs stay 0, and o_rsp_data=0x57/id=0 holds for 5 cycles. Raise i_rsp_ready → the pending request is accepted that same cycle (pop+push).
- Wrap-around: ADD 0xFFFFFFFF+0x1 on req1 → data=0x00000000, id=1.
- Reset mid-operation: assert i_rst while FULL with i_rsp_ready=0 → next cycle o_rsp_valid=0 and o_rsp_data=0. A later conflict grants requester 0 first.
- Idle: no valids for 10 cycles after draining → o_rsp_valid stays 0, both ready outputs stay 0, last_grant unchanged.
